// File: rtl/alu_pkg.sv
// alu_pkg: ALU operation codes, ALUOp classes, R-type opcodes and issue-controller state encoding
// shared by the ALU, its issue controller and their benches.
package alu_pkg;
   typedef enum logic [3:0] {
      OP_AND   = 4'b0000,
      OP_ORR   = 4'b0001,
      OP_ADD   = 4'b0010,
      OP_SUB   = 4'b0110,
      OP_PASSB = 4'b0111,
      OP_NOR   = 4'b1100
   } alu_op_e;
   typedef enum logic [1:0] {
      ALUOP_LS  = 2'b00,
      ALUOP_BR  = 2'b01,
      ALUOP_R   = 2'b10,
      ALUOP_NOR = 2'b11
   } aluop_e;
   localparam logic [10:0] OPC_ADD = 11'b10001011000;
   localparam logic [10:0] OPC_SUB = 11'b11001011000;
   localparam logic [10:0] OPC_AND = 11'b10001010000;
   localparam logic [10:0] OPC_ORR = 11'b10101010000;
   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_EXEC = 2'b01,
      S_RESP = 2'b10
   } state_e;
endpackage

// File: rtl/alu_op_decode.sv
// alu_op_decode: maps (ALUOp class, instruction[31:21]) to the ALU operation code;
// R-type opcodes without a mapping are flagged illegal.
module alu_op_decode
   import alu_pkg::*;
(
   input  logic [1:0]  aluop,
   input  logic [10:0] opcode,
   output logic [3:0]  operation,
   output logic        illegal
);
   always_comb begin
      operation = OP_ADD;
      illegal   = 1'b0;
      case (aluop)
         ALUOP_LS:  operation = OP_ADD;
         ALUOP_BR:  operation = OP_PASSB;
         ALUOP_NOR: operation = OP_NOR;
         default: begin
            case (opcode)
               OPC_ADD: operation = OP_ADD;
               OPC_SUB: operation = OP_SUB;
               OPC_AND: operation = OP_AND;
               OPC_ORR: operation = OP_ORR;
               default: illegal = 1'b1;
            endcase
         end
      endcase
   end
endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: multi-cycle sequencer that issues decoded requests to the ALU, holds its
// inputs for ALU_LAT cycles, captures the result and returns it over a valid/ready response.
module alu_issue_ctrl
   import alu_pkg::*;
#(
   parameter int ALU_LAT = 1,
   parameter int WIDTH   = 64
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [1:0]       req_aluop,
   input  logic [10:0]      req_opcode,
   input  logic [WIDTH-1:0] req_a,
   input  logic [WIDTH-1:0] req_b,
   output logic [3:0]       alu_operation,
   output logic [WIDTH-1:0] alu_i0,
   output logic [WIDTH-1:0] alu_i1,
   input  logic [WIDTH-1:0] alu_out,
   input  logic             alu_zero,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_result,
   output logic             rsp_zero,
   output logic             rsp_illegal
);
   state_e     state, state_n;
   logic [3:0] cnt;
   logic [3:0] dec_op;
   logic       dec_illegal;
   logic       accept;

   alu_op_decode u_dec (
      .aluop     (req_aluop),
      .opcode    (req_opcode),
      .operation (dec_op),
      .illegal   (dec_illegal)
   );

   assign req_ready = state == S_IDLE;
   assign rsp_valid = state == S_RESP;
   assign accept    = req_ready && req_valid;

   always_comb begin
      state_n = state;
      case (state)
         S_IDLE:  state_n = req_valid ? (dec_illegal ? S_RESP : S_EXEC) : S_IDLE;
         S_EXEC:  state_n = (cnt == 4'd1) ? S_RESP : S_EXEC;
         S_RESP:  state_n = rsp_ready ? S_IDLE : S_RESP;
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= S_IDLE;
         cnt           <= 4'd0;
         alu_operation <= 4'b0000;
         alu_i0        <= '0;
         alu_i1        <= '0;
         rsp_result    <= '0;
         rsp_zero      <= 1'b0;
         rsp_illegal   <= 1'b0;
      end else begin
         state <= state_n;
         // Illegal requests never reach the ALU, so its drive keeps the last issued values.
         if (accept && !dec_illegal) begin
            alu_operation <= dec_op;
            alu_i0        <= req_a;
            alu_i1        <= req_b;
            cnt           <= 4'(ALU_LAT);
         end
         if (accept && dec_illegal) begin
            rsp_result  <= '0;
            rsp_zero    <= 1'b0;
            rsp_illegal <= 1'b1;
         end
         if (state == S_EXEC) begin
            cnt <= cnt - 4'd1;
            if (cnt == 4'd1) begin
               rsp_result  <= alu_out;
               rsp_zero    <= alu_zero;
               rsp_illegal <= 1'b0;
            end
         end
      end
   end
endmodule
